// File: rtl/clk_div_prog_if.sv
// Configuration port of the programmable clock divider: one divisor request per
// valid/ready handshake, addressed to a single channel.
interface clk_div_prog_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 1
);
    logic             cfg_valid;
    logic [CW-1:0]    cfg_ch;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;

    modport master (output cfg_valid, output cfg_ch, output cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ch, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable clock divider. Each channel produces a registered
// divided clock and a period-start strobe; new divisors take effect at period boundaries.
module clk_div_prog #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 2,
    parameter int DEFAULT_DIV = 6
) (
    input  logic                clk,
    input  logic                reset,
    clk_div_prog_if.slave       cfg,
    input  logic                sync,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);
    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DEF_CNT = WIDTH'(DEFAULT_DIV - 1);

    // High-phase length ceil(N/2), kept one bit wider so N = 2^WIDTH-1 cannot overflow.
    function automatic logic [WIDTH:0] high_len(input logic [WIDTH-1:0] n);
        return ({1'b0, n} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    endfunction

    logic [CHANNELS-1:0] pending_s;

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_ch
            logic [WIDTH-1:0] div_act_r;
            logic [WIDTH-1:0] cnt_r;
            logic [WIDTH-1:0] pend_div_r;
            logic             pending_r;
            logic             clk_out_r;
            logic             tick_r;

            logic             accept_s;
            logic             last_s;
            logic             apply_s;
            logic             wrap_s;
            logic [WIDTH-1:0] div_next_s;
            logic [WIDTH-1:0] cnt_next_s;
            logic             clk_out_next_s;
            logic             tick_next_s;

            // Next-state decode: apply a queued divisor, wrap, hold when stopped, else count.
            always_comb begin
                accept_s       = cfg.cfg_valid && !pending_r && (int'(cfg.cfg_ch) == g);
                last_s         = (cnt_r == (div_act_r - ONE_W));
                apply_s        = pending_r && (sync || (div_act_r == ZERO_W) || last_s);
                div_next_s     = apply_s ? pend_div_r : div_act_r;
                wrap_s         = apply_s || sync || last_s;
                cnt_next_s     = cnt_r;
                clk_out_next_s = 1'b0;
                tick_next_s    = 1'b0;
                if (wrap_s) begin
                    cnt_next_s = ZERO_W;
                end else if (div_act_r == ZERO_W) begin
                    cnt_next_s = cnt_r;
                end else begin
                    cnt_next_s = cnt_r + ONE_W;
                end
                // A zero divisor (including one just applied) parks the output low.
                if (div_next_s == ZERO_W) begin
                    clk_out_next_s = 1'b0;
                    tick_next_s    = 1'b0;
                end else begin
                    clk_out_next_s = ({1'b0, cnt_next_s} < high_len(div_next_s));
                    tick_next_s    = (cnt_next_s == ZERO_W);
                end
            end

            // Channel state and registered outputs.
            always_ff @(posedge clk) begin
                if (reset) begin
                    div_act_r  <= DEF_DIV;
                    cnt_r      <= DEF_CNT;
                    pend_div_r <= ZERO_W;
                    pending_r  <= 1'b0;
                    clk_out_r  <= 1'b0;
                    tick_r     <= 1'b0;
                end else begin
                    div_act_r <= div_next_s;
                    cnt_r     <= cnt_next_s;
                    clk_out_r <= clk_out_next_s;
                    tick_r    <= tick_next_s;
                    if (accept_s) begin
                        pending_r  <= 1'b1;
                        pend_div_r <= cfg.cfg_div;
                    end else if (apply_s) begin
                        pending_r  <= 1'b0;
                        pend_div_r <= pend_div_r;
                    end else begin
                        pending_r  <= pending_r;
                        pend_div_r <= pend_div_r;
                    end
                end
            end

            assign pending_s[g] = pending_r;
            assign clk_out[g]   = clk_out_r;
            assign tick[g]      = tick_r;
        end
    endgenerate

    // Ready reflects the addressed channel; out-of-range channels always accept and discard.
    always_comb begin
        cfg.cfg_ready = 1'b1;
        if (int'(cfg.cfg_ch) < CHANNELS) begin
            cfg.cfg_ready = ~pending_s[cfg.cfg_ch];
        end else begin
            cfg.cfg_ready = 1'b1;
        end
    end
endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Multi-channel, runtime-programmable clock divider; parametrised successor of the fixed divide-by-6 block. Each channel derives a registered divided clock and a one-cycle period-start strobe from the single system clock. Divisors are loaded through a valid/ready port and take effect glitch-free at the channel's next period boundary. Sits beside the system clock source and feeds slow-domain enables and test/observation clocks.

## Interface

Parameters:
- `WIDTH`, default 8: divisor width. Valid divisors are 0..2^WIDTH-1.
- `CHANNELS`, default 2: number of independent channels, at least 1.
- `DEFAULT_DIV`, default 6: divisor loaded into every channel by reset.
- `CW`, derived: `max(1, $clog2(CHANNELS))`.

Ports:
- `clk`, in, 1: system clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `cfg_valid`, in, 1: configuration request.
- `cfg_ch`, in, CW: target channel. Values ≥ CHANNELS are accepted and discarded.
- `cfg_div`, in, WIDTH: new divisor N.
- `cfg_ready`, out, 1: combinational; equals `~pending[cfg_ch]`. It is 1 for out-of-range `cfg_ch`.
- `sync`, in, 1: restarts all channels in phase.
- `clk_out`, out, CHANNELS: divided clocks, registered.
- `tick`, out, CHANNELS: one-cycle strobe on the cycle `clk_out` begins a period, registered.

## Operation

Per-channel state:
- `div_act` (WIDTH): active divisor.
- `cnt` (WIDTH): position within the period.
- `pend_div` (WIDTH) and `pending` (1): a queued divisor.

Derived quantities:
- `H = (N+1)>>1`, computed at WIDTH+1 bits. This gives the high phase as ceil(N/2).
- N=6 → high 3 / low 3. N=5 → high 3 / low 2.

Reset, evaluated on every edge with `reset`=1:
- `div_act` = DEFAULT_DIV.
- `cnt` = DEFAULT_DIV-1, so the first edge after release wraps.
- `pending` = 0, `clk_out` = 0, `tick` = 0.
- Reset mid-operation discards queued divisors and restarts every channel identically.

Configuration handshake:
- A request is accepted on an edge where `cfg_valid & cfg_ready`; this sets `pending` and `pend_div`.
- `cfg_ready` for that channel stays low until the edge that applies the value, and is high again in the following cycle.
- Requests to other channels are independent.

Per-channel next state on each non-reset edge, in priority order:
1. **Apply condition** (`pending` already set before this edge) AND (`sync`, OR `div_act`==0, OR `cnt`==`div_act`-1):
   - `div_act` ← `pend_div`, `pending` ← 0.
   - Then treat as a wrap using the new divisor.
2. **Wrap** (`sync`, OR `cnt`==`div_act`-1):
   - `cnt` ← 0.
3. **Stopped** (`div_act`==0):
   - `cnt` holds, `clk_out` ← 0, `tick` ← 0.
4. **Otherwise:**
   - `cnt` ← `cnt`+1.
- Whenever the channel is not stopped: `clk_out` ← (`cnt_next` < H), and `tick` ← (`cnt_next`==0).

Mode rules:
- **N=0:** channel stopped and output low. A pending nonzero value starts it on the next edge, with `clk_out`=1 and `tick`=1 on that edge.
- **N=1:** `cnt` stays 0, `clk_out` is constant 1, and `tick` is 1 every cycle.
- **N≥2:** period N cycles, high for H cycles, `tick` on the first high cycle.
- **`sync`:** applies to all channels at the same edge. Stopped channels stay stopped unless a nonzero divisor is pending.

## Timing

Latency:
- Reset release → first `clk_out` rise and `tick` on the first non-reset edge.
- Config accepted at edge E → applied at the earliest edge after E that meets the apply condition.
  - Worst case is E + `div_act` edges.
  - If E itself is a wrap edge, the value waits for the next boundary.
- `sync` at edge E → `tick`=1 and `clk_out`=1 for all running channels after E.

Boundary conditions:
- Accept and apply never occur on the same edge for the same channel.
- The output never produces a runt pulse: every high or low phase lasts its full length under the old or the new divisor.
- N = 2^WIDTH-1: `cnt` reaches 2^WIDTH-2 and must not overflow; H = 2^(WIDTH-1).

## Test plan

- **Reset default (CHANNELS=2, DEFAULT_DIV=6).** Pulse `reset` for 1 cycle, then release → both `clk_out` run 111000 repeating; `tick` pulses on edges 1, 7, 13 after release; `cfg_ready`=1.
- **Odd divisor.** Load ch0 with 5 mid-period → ch0 finishes its current 6-cycle period, then runs 11100 with period 5. `cfg_ready`(ch0) is low from accept until the apply edge. ch1 is unaffected.
- **Stop/start.** Load 0 → `clk_out`[0] goes low at the boundary and `tick` stops. Then load 4 → on the edge after accept, `clk_out`=1 and `tick`=1, followed by 1100 repeating.
- **N=1 and max.** Load 1 → `clk_out` constant 1 and `tick` every cycle. Load 255 (WIDTH=8) → 128 high / 127 low, period 255, no wrap error.
- **Sync and simultaneity.** Set ch0=6 and ch1=4, out of phase. Assert `sync` for 1 cycle on the same edge that ch1 has a pending 3 → both channels `tick` together; ch1 immediately runs 110.
- **Handshake and reset mid-operation.** Hold `cfg_valid` to a busy channel → no second accept until `cfg_ready` rises. Assert `reset` while a divisor is pending → pending is dropped and all channels return to 111000.
